// File: rtl/ysyx_24080006_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_pkg
// Shared types and constants for the AXI arbiter and the downstream crossbar.
//   rd_state_e      : read-path FSM states
//   wr_state_e      : write-path FSM states
//   grant_e         : which upstream master owns the read path
//   XBAR_SPLIT_ADDR : address split point used by ysyx_24080006_jtag_xbar
//   AXI_*_W         : channel field widths used by the AXI interface
// ---------------------------------------------------------------------------
package ysyx_24080006_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IFU  = 2'd1,
    R_LSU  = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  localparam logic [31:0] XBAR_SPLIT_ADDR = 32'h0200_0000;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

endpackage

// File: rtl/ysyx_24080006_axi.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi
// AXI4 bundle (AW, W, B, AR, R) with master and slave views.
//   master : drives AW/W/AR payload + valid, rready, bready
//   slave  : drives awready, wready, arready, B payload + valid, R payload + valid
// ---------------------------------------------------------------------------
interface ysyx_24080006_axi;
  import ysyx_24080006_axi_pkg::*;

  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_ID_W-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic [AXI_ID_W-1:0]     bid;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_ID_W-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [AXI_ID_W-1:0]     rid;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bid, bvalid, output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rid, rvalid, output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bid, bvalid, input bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rid, rvalid, input rready
  );

endinterface

// File: rtl/ysyx_24080006_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_rr_arb2
// Two-request arbiter producing a one-hot grant (bit 0 = IFU, bit 1 = LSU).
//   FAIR = 0 : LSU always wins a tie.
//   FAIR = 1 : a tie goes to the requester that was not granted last.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   req[1:0]       : request vector
//   advance        : grant is being consumed this cycle (updates history)
//   gnt[1:0]       : one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module ysyx_24080006_rr_arb2
  import ysyx_24080006_axi_pkg::*;
#(
  parameter bit FAIR = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  grant_e     last_grant_q;
  grant_e     last_grant_d;
  logic [1:0] prefer;

  // A requester wins when the other is idle or when it holds the tie-break.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bit
      if (FAIR) begin : g_rr
        assign prefer[gi] = (logic'(last_grant_q) != 1'(gi));
      end else begin : g_fixed
        assign prefer[gi] = (gi == 1);
      end
      assign gnt[gi] = req[gi] & (~req[1-gi] | prefer[gi]);
    end
  endgenerate

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && (|gnt)) begin
      last_grant_d = gnt[1] ? GNT_LSU : GNT_IFU;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q <= GNT_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ysyx_24080006_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_arbiter
// Merges the IFU and LSU AXI masters onto one downstream master port.
// Reads from both masters are arbitrated and held for a whole burst; writes
// come only from the LSU and are sequenced AW -> W -> B. Read and write paths
// are independent and may be active together.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   axi_ifu        : IFU master (read channels only; write channels refused)
//   axi_lsu        : LSU master (all channels)
//   axi_out        : downstream master port toward the crossbar
// ---------------------------------------------------------------------------
module ysyx_24080006_axi_arbiter
  import ysyx_24080006_axi_pkg::*;
#(
  parameter bit FAIR = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ysyx_24080006_axi.slave       axi_ifu,
  ysyx_24080006_axi.slave       axi_lsu,
  ysyx_24080006_axi.master      axi_out
);

  // out_en_q keeps every valid/ready low from the reset edge until the cycle
  // after reset is released, even though most paths are combinational.
  logic      out_en_q;
  logic      out_en_d;

  rd_state_e rd_state_q, rd_state_d;
  logic      ar_done_q, ar_done_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [1:0] rd_req;
  logic [1:0] rd_gnt;

  // Read-path handshake signals (after gating).
  logic out_arvalid, out_rready;
  logic ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid;

  // Write-path handshake signals (after gating).
  logic out_awvalid, out_wvalid, out_bready;
  logic lsu_awready, lsu_wready, lsu_bvalid;

  assign out_en_d = 1'b1;

  // ------------------------------------------------------------------ arbiter
  assign rd_req = {out_en_q & axi_lsu.arvalid, out_en_q & axi_ifu.arvalid};

  ysyx_24080006_rr_arb2 #(.FAIR(FAIR)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (rd_req),
    .advance (rd_state_q == R_IDLE),
    .gnt     (rd_gnt)
  );

  // --------------------------------------------------------- state registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_en_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      ar_done_q  <= 1'b0;
      wr_state_q <= W_IDLE;
    end else begin
      out_en_q   <= out_en_d;
      rd_state_q <= rd_state_d;
      ar_done_q  <= ar_done_d;
      wr_state_q <= wr_state_d;
    end
  end

  // ----------------------------------------------------- read next-state
  always_comb begin
    rd_state_d = rd_state_q;
    ar_done_d  = ar_done_q;
    unique case (rd_state_q)
      R_IDLE: begin
        ar_done_d = 1'b0;
        if (rd_gnt[1]) begin
          rd_state_d = R_LSU;
        end else if (rd_gnt[0]) begin
          rd_state_d = R_IFU;
        end
      end
      R_IFU, R_LSU: begin
        if (out_arvalid && axi_out.arready) begin
          ar_done_d = 1'b1;
        end
        if (out_rready && axi_out.rvalid && axi_out.rlast) begin
          rd_state_d = R_IDLE;
          ar_done_d  = 1'b0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ----------------------------------------------------- read outputs
  // AR is only offered until its handshake; a second arvalid from the same
  // master within the burst is held off until the next grant.
  always_comb begin
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    unique case (rd_state_q)
      R_IFU: begin
        out_arvalid = out_en_q & ~ar_done_q & axi_ifu.arvalid;
        ifu_arready = out_en_q & ~ar_done_q & axi_out.arready;
        ifu_rvalid  = out_en_q & axi_out.rvalid;
        out_rready  = out_en_q & axi_ifu.rready;
      end
      R_LSU: begin
        out_arvalid = out_en_q & ~ar_done_q & axi_lsu.arvalid;
        lsu_arready = out_en_q & ~ar_done_q & axi_out.arready;
        lsu_rvalid  = out_en_q & axi_out.rvalid;
        out_rready  = out_en_q & axi_lsu.rready;
      end
      default: ;
    endcase
  end

  assign axi_out.araddr  = (rd_state_q == R_LSU) ? axi_lsu.araddr  : axi_ifu.araddr;
  assign axi_out.arid    = (rd_state_q == R_LSU) ? axi_lsu.arid    : axi_ifu.arid;
  assign axi_out.arlen   = (rd_state_q == R_LSU) ? axi_lsu.arlen   : axi_ifu.arlen;
  assign axi_out.arsize  = (rd_state_q == R_LSU) ? axi_lsu.arsize  : axi_ifu.arsize;
  assign axi_out.arburst = (rd_state_q == R_LSU) ? axi_lsu.arburst : axi_ifu.arburst;
  assign axi_out.arvalid = out_arvalid;
  assign axi_out.rready  = out_rready;

  assign axi_ifu.arready = ifu_arready;
  assign axi_lsu.arready = lsu_arready;

  // R payload is broadcast; only rvalid selects the receiving master.
  assign axi_ifu.rvalid = ifu_rvalid;
  assign axi_ifu.rdata  = axi_out.rdata;
  assign axi_ifu.rresp  = axi_out.rresp;
  assign axi_ifu.rlast  = axi_out.rlast;
  assign axi_ifu.rid    = axi_out.rid;
  assign axi_lsu.rvalid = lsu_rvalid;
  assign axi_lsu.rdata  = axi_out.rdata;
  assign axi_lsu.rresp  = axi_out.rresp;
  assign axi_lsu.rlast  = axi_out.rlast;
  assign axi_lsu.rid    = axi_out.rid;

  // ----------------------------------------------------- write next-state
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE: if (out_awvalid && axi_out.awready) wr_state_d = W_DATA;
      W_DATA: if (out_wvalid && axi_out.wready && axi_lsu.wlast) wr_state_d = W_RESP;
      W_RESP: if (lsu_bvalid && axi_lsu.bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // ----------------------------------------------------- write outputs
  // W stays blocked in W_IDLE so data can never overtake its address.
  always_comb begin
    out_awvalid = 1'b0;
    lsu_awready = 1'b0;
    out_wvalid  = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    out_bready  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        out_awvalid = out_en_q & axi_lsu.awvalid;
        lsu_awready = out_en_q & axi_out.awready;
      end
      W_DATA: begin
        out_wvalid = out_en_q & axi_lsu.wvalid;
        lsu_wready = out_en_q & axi_out.wready;
      end
      W_RESP: begin
        lsu_bvalid = out_en_q & axi_out.bvalid;
        out_bready = out_en_q & axi_lsu.bready;
      end
      default: ;
    endcase
  end

  assign axi_out.awaddr  = axi_lsu.awaddr;
  assign axi_out.awid    = axi_lsu.awid;
  assign axi_out.awlen   = axi_lsu.awlen;
  assign axi_out.awsize  = axi_lsu.awsize;
  assign axi_out.awburst = axi_lsu.awburst;
  assign axi_out.awvalid = out_awvalid;
  assign axi_out.wdata   = axi_lsu.wdata;
  assign axi_out.wstrb   = axi_lsu.wstrb;
  assign axi_out.wlast   = axi_lsu.wlast;
  assign axi_out.wvalid  = out_wvalid;
  assign axi_out.bready  = out_bready;

  assign axi_lsu.awready = lsu_awready;
  assign axi_lsu.wready  = lsu_wready;
  assign axi_lsu.bvalid  = lsu_bvalid;
  assign axi_lsu.bresp   = axi_out.bresp;
  assign axi_lsu.bid     = axi_out.bid;

  // The IFU never writes: its write channels are refused outright.
  assign axi_ifu.awready = 1'b0;
  assign axi_ifu.wready  = 1'b0;
  assign axi_ifu.bvalid  = 1'b0;
  assign axi_ifu.bresp   = 2'b00;
  assign axi_ifu.bid     = '0;

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
module tb_ysyx_24080006_axi_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  ysyx_24080006_axi i0();
  ysyx_24080006_axi l0();
  ysyx_24080006_axi o0();
  ysyx_24080006_axi i1();
  ysyx_24080006_axi l1();
  ysyx_24080006_axi o1();

  ysyx_24080006_axi_arbiter #(.FAIR(1'b0)) u_fixed (
    .clock   (clock),
    .reset_n (reset_n),
    .axi_ifu (i0),
    .axi_lsu (l0),
    .axi_out (o0)
  );

  ysyx_24080006_axi_arbiter #(.FAIR(1'b1)) u_fair (
    .clock   (clock),
    .reset_n (reset_n),
    .axi_ifu (i1),
    .axi_lsu (l1),
    .axi_out (o1)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // quiet all bench-driven handshakes and payloads
    i0.arvalid = 0; i0.araddr = 0; i0.arid = 0; i0.arlen = 0; i0.arsize = 3'd2; i0.arburst = 2'b01;
    i0.rready = 1; i0.awvalid = 0; i0.wvalid = 0; i0.bready = 0;
    i0.awaddr = 0; i0.awid = 0; i0.awlen = 0; i0.awsize = 0; i0.awburst = 0;
    i0.wdata = 0; i0.wstrb = 0; i0.wlast = 0;
    l0.arvalid = 0; l0.araddr = 0; l0.arid = 4'd1; l0.arlen = 0; l0.arsize = 3'd2; l0.arburst = 2'b01;
    l0.rready = 1; l0.awvalid = 0; l0.wvalid = 0; l0.bready = 1;
    l0.awaddr = 0; l0.awid = 4'd1; l0.awlen = 0; l0.awsize = 3'd2; l0.awburst = 2'b01;
    l0.wdata = 0; l0.wstrb = 0; l0.wlast = 0;
    o0.arready = 1; o0.awready = 0; o0.wready = 0; o0.bvalid = 0; o0.bresp = 0; o0.bid = 0;
    o0.rvalid = 0; o0.rdata = 0; o0.rresp = 0; o0.rlast = 0; o0.rid = 0;
    i1.arvalid = 0; i1.araddr = 0; i1.arid = 0; i1.arlen = 0; i1.arsize = 3'd2; i1.arburst = 2'b01;
    i1.rready = 1; i1.awvalid = 0; i1.wvalid = 0; i1.bready = 0;
    i1.awaddr = 0; i1.awid = 0; i1.awlen = 0; i1.awsize = 0; i1.awburst = 0;
    i1.wdata = 0; i1.wstrb = 0; i1.wlast = 0;
    l1.arvalid = 0; l1.araddr = 0; l1.arid = 4'd1; l1.arlen = 0; l1.arsize = 3'd2; l1.arburst = 2'b01;
    l1.rready = 1; l1.awvalid = 0; l1.wvalid = 0; l1.bready = 0;
    l1.awaddr = 0; l1.awid = 0; l1.awlen = 0; l1.awsize = 0; l1.awburst = 0;
    l1.wdata = 0; l1.wstrb = 0; l1.wlast = 0;
    o1.arready = 1; o1.awready = 0; o1.wready = 0; o1.bvalid = 0; o1.bresp = 0; o1.bid = 0;
    o1.rvalid = 0; o1.rdata = 0; o1.rresp = 0; o1.rlast = 0; o1.rid = 0;

    // ---------------- reset: forwarded valids must stay low
    l0.awvalid = 1;
    tick(); tick(); #1;
    chk("rst_awvalid", o0.awvalid, 0);
    chk("rst_arready", l0.arready, 0);
    l0.awvalid = 0;
    reset_n = 1;
    tick();

    // ---------------- IFU-only single read
    i0.arvalid = 1; i0.araddr = 32'h3000_0000; i0.arlen = 0;
    #1 chk("ifu_ar_lat0", o0.arvalid, 0);
    tick(); #1;
    chk("ifu_ar_lat1", o0.arvalid, 1);
    chk("ifu_araddr", o0.araddr, 32'h3000_0000);
    chk("ifu_arready", i0.arready, 1);
    tick();
    i0.arvalid = 0;
    o0.rvalid = 1; o0.rdata = 32'hDEAD_BEEF; o0.rlast = 1;
    #1;
    chk("ifu_ar_done", o0.arvalid, 0);
    chk("ifu_rvalid", i0.rvalid, 1);
    chk("ifu_rdata", i0.rdata, 32'hDEAD_BEEF);
    chk("ifu_rlast", i0.rlast, 1);
    chk("ifu_lsu_rvalid", l0.rvalid, 0);
    chk("ifu_rready", o0.rready, 1);
    tick();
    o0.rvalid = 0; o0.rlast = 0;

    // ---------------- FAIR=0 contention: LSU, bubble, IFU
    i0.arvalid = 1; i0.araddr = 32'h3000_0004;
    l0.arvalid = 1; l0.araddr = 32'h8000_0000;
    tick(); #1;
    chk("fix_win_addr", o0.araddr, 32'h8000_0000);
    chk("fix_lsu_arready", l0.arready, 1);
    chk("fix_ifu_wait", i0.arready, 0);
    tick();
    l0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 1; o0.rdata = 32'h1111_1111;
    #1;
    chk("fix_lsu_rvalid", l0.rvalid, 1);
    chk("fix_ifu_no_r", i0.rvalid, 0);
    tick();
    o0.rvalid = 0; o0.rlast = 0;
    #1 chk("fix_bubble", o0.arvalid, 0);
    tick(); #1;
    chk("fix_ifu_arvalid", o0.arvalid, 1);
    chk("fix_ifu_addr", o0.araddr, 32'h3000_0004);
    tick();
    i0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 1;
    tick();
    o0.rvalid = 0; o0.rlast = 0;

    // ---------------- LSU 4-beat burst, IFU arrives at beat 2
    l0.arvalid = 1; l0.araddr = 32'h8000_0100; l0.arlen = 8'd3;
    tick();
    tick();
    l0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 0; o0.rdata = 32'hB000_0000;
    #1 chk("bst_beat1", l0.rvalid, 1);
    tick();
    o0.rdata = 32'hB000_0001;
    i0.arvalid = 1; i0.araddr = 32'h3000_0008;
    #1;
    chk("bst_b2_ifu_r", i0.rvalid, 0);
    chk("bst_b2_ifu_ar", i0.arready, 0);
    tick();
    o0.rdata = 32'hB000_0002;
    tick();
    o0.rdata = 32'hB000_0003; o0.rlast = 1;
    #1;
    chk("bst_b4_ifu_r", i0.rvalid, 0);
    chk("bst_b4_lsu_r", l0.rvalid, 1);
    tick();
    o0.rvalid = 0; o0.rlast = 0;
    #1;
    chk("bst_idle_ifu_ar", i0.arready, 0);
    chk("bst_idle_arvalid", o0.arvalid, 0);
    tick(); #1;
    chk("bst_ifu_grant", i0.arready, 1);
    chk("bst_ifu_addr", o0.araddr, 32'h3000_0008);
    tick();
    i0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 1;
    tick();
    o0.rvalid = 0; o0.rlast = 0;

    // ---------------- LSU write with W offered before AW
    l0.wvalid = 1; l0.wdata = 32'h1234_5678; l0.wstrb = 4'hF; l0.wlast = 1;
    o0.wready = 1;
    #1;
    chk("wr_w_blocked", l0.wready, 0);
    chk("wr_w_no_fwd", o0.wvalid, 0);
    tick();
    l0.awvalid = 1; l0.awaddr = 32'h0F00_0010;
    o0.awready = 1;
    #1;
    chk("wr_awvalid", o0.awvalid, 1);
    chk("wr_awaddr", o0.awaddr, 32'h0F00_0010);
    chk("wr_awready", l0.awready, 1);
    chk("wr_w_still_blk", l0.wready, 0);
    tick();
    l0.awvalid = 0;
    #1;
    chk("wr_wready", l0.wready, 1);
    chk("wr_wdata", o0.wdata, 32'h1234_5678);
    chk("wr_wstrb", o0.wstrb, 32'hF);
    chk("wr_aw_closed", o0.awvalid, 0);
    tick();
    l0.wvalid = 0;
    o0.bvalid = 1; o0.bresp = 2'b00;
    #1;
    chk("wr_bvalid", l0.bvalid, 1);
    chk("wr_bresp", l0.bresp, 0);
    chk("wr_bready", o0.bready, 1);
    chk("wr_resp_wready", l0.wready, 0);
    tick();
    o0.bvalid = 0;
    o0.awready = 0;
    l0.awvalid = 1;
    #1 chk("wr_back_idle", o0.awvalid, 1);
    l0.awvalid = 0;

    // ---------------- concurrent LSU write + IFU read, IFU write refused
    i0.arvalid = 1; i0.araddr = 32'h3000_000C;
    l0.awvalid = 1; l0.awaddr = 32'h0F00_0020;
    o0.awready = 1;
    i0.awvalid = 1; i0.wvalid = 1;
    #1;
    chk("cc_awvalid", o0.awvalid, 1);
    chk("cc_ifu_awready", i0.awready, 0);
    tick();
    l0.awvalid = 0;
    l0.wvalid = 1; l0.wlast = 1; l0.wdata = 32'hCAFE_0001;
    #1;
    chk("cc_arvalid", o0.arvalid, 1);
    chk("cc_wvalid", o0.wvalid, 1);
    chk("cc_ifu_wready", i0.wready, 0);
    tick();
    i0.arvalid = 0; l0.wvalid = 0;
    o0.rvalid = 1; o0.rlast = 1; o0.rdata = 32'h5555_5555;
    o0.bvalid = 1;
    #1;
    chk("cc_ifu_rvalid", i0.rvalid, 1);
    chk("cc_lsu_bvalid", l0.bvalid, 1);
    chk("cc_ifu_bvalid", i0.bvalid, 0);
    tick();
    o0.rvalid = 0; o0.rlast = 0; o0.bvalid = 0;
    i0.awvalid = 0; i0.wvalid = 0;

    // ---------------- reset pulse in the middle of a 4-beat burst
    l0.arvalid = 1; l0.araddr = 32'h8000_0200; l0.arlen = 8'd3;
    tick();
    tick();
    l0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 0;
    tick();
    reset_n = 0;
    #1 chk("mid_beat2", l0.rvalid, 1);
    tick();
    reset_n = 1;
    l0.awvalid = 1;
    #1;
    chk("mid_rst_rvalid", l0.rvalid, 0);
    chk("mid_rst_rready", o0.rready, 0);
    chk("mid_rst_awvalid", o0.awvalid, 0);
    chk("mid_rst_arready", l0.arready, 0);
    o0.rvalid = 0;
    l0.awvalid = 0;
    tick();
    i0.arvalid = 1; i0.araddr = 32'h3000_0010; i0.arlen = 0;
    #1 chk("post_rst_lat0", o0.arvalid, 0);
    tick(); #1;
    chk("post_rst_arvalid", o0.arvalid, 1);
    chk("post_rst_addr", o0.araddr, 32'h3000_0010);
    chk("post_rst_arready", i0.arready, 1);
    tick();
    i0.arvalid = 0;
    o0.rvalid = 1; o0.rlast = 1;
    #1 chk("post_rst_rvalid", i0.rvalid, 1);
    tick();
    o0.rvalid = 0; o0.rlast = 0;

    // ---------------- FAIR=1: three ties go LSU, IFU, LSU
    i1.arvalid = 1; i1.araddr = 32'h3000_0100;
    l1.arvalid = 1; l1.araddr = 32'h8000_0100;
    tick(); #1;
    chk("rr_g1_addr", o1.araddr, 32'h8000_0100);
    chk("rr_g1_lsu", l1.arready, 1);
    chk("rr_g1_ifu", i1.arready, 0);
    tick();
    l1.araddr = 32'h8000_0104;
    o1.rvalid = 1; o1.rlast = 1;
    #1 chk("rr_g1_r", l1.rvalid, 1);
    tick();
    o1.rvalid = 0; o1.rlast = 0;
    #1 chk("rr_bubble1", o1.arvalid, 0);
    tick(); #1;
    chk("rr_g2_addr", o1.araddr, 32'h3000_0100);
    chk("rr_g2_ifu", i1.arready, 1);
    tick();
    i1.araddr = 32'h3000_0104;
    o1.rvalid = 1; o1.rlast = 1;
    #1 chk("rr_g2_r", i1.rvalid, 1);
    tick();
    o1.rvalid = 0; o1.rlast = 0;
    tick(); #1;
    chk("rr_g3_addr", o1.araddr, 32'h8000_0104);
    chk("rr_g3_lsu", l1.arready, 1);
    tick();
    i1.arvalid = 0; l1.arvalid = 0;
    o1.rvalid = 1; o1.rlast = 1;
    tick();
    o1.rvalid = 0; o1.rlast = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
